// File: rtl/sector_cache_pkg.sv
// Shared types and constants for the single-sector disk cache.
package sector_cache_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int ADDR_W       = $clog2(SECTOR_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_XFER,
        RD_REQ,
        RD_XFER,
        DONE
    } state_e;

endpackage

// File: rtl/sector_cache_ctrl_if.sv
// SD sector handshake between the cache (master) and image_controller (slave).
interface sector_cache_ctrl_if #(
    parameter int LBA_W = 32
);
    import sector_cache_pkg::*;

    logic [LBA_W-1:0]  sd_lba;
    logic [1:0]        sd_rd;
    logic [1:0]        sd_wr;
    logic              sd_ack;
    logic [ADDR_W-1:0] sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din;
    logic              sd_buff_wr;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

endinterface

// File: rtl/sector_ram.sv
// 512x8 sector buffer: one write port, async SD-side read, registered CPU-side read.
module sector_ram
    import sector_cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_dout,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_dout
);

    logic [7:0] mem [SECTOR_BYTES];

    // NOTE: the array has no reset so it maps onto plain RAM; only the output register is reset.
    always_ff @(posedge clk_i) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign sd_dout = mem[sd_addr];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            cpu_dout <= '0;
        else
            cpu_dout <= mem[cpu_addr];
    end

endmodule

// File: rtl/sector_cache_ctrl.sv
// One-sector write-back cache between the FDC glue and image_controller.
module sector_cache_ctrl
    import sector_cache_pkg::*;
#(
    parameter int          LBA_W       = 32,
    parameter logic [15:0] ACK_TIMEOUT = 16'hFFFF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [LBA_W-1:0]  req_lba,
    input  logic              req_rd,
    input  logic              req_flush,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_we,
    output logic [7:0]        cpu_dout,
    sector_cache_ctrl_if.master sd
);

    state_e            state;
    logic              valid, dirty, rd_pending;
    logic              rd_req, wr_req;
    logic [LBA_W-1:0]  cached_lba, target_lba, lba_q;
    logic [15:0]       tmo_cnt;
    logic              hit, cpu_wr_ok, sd_wr_ok, in_xfer, advance, tmo_hit;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    assign hit       = valid && (req_lba == cached_lba);
    assign cpu_wr_ok = cpu_we && valid && !busy;
    assign sd_wr_ok  = (state == RD_XFER) && sd.sd_buff_wr;
    assign in_xfer   = state inside {WB_REQ, WB_XFER, RD_REQ, RD_XFER};
    // Request states advance on ack rising, transfer states on ack falling.
    assign advance   = ((state == WB_REQ  || state == RD_REQ)  &&  sd.sd_ack) ||
                       ((state == WB_XFER || state == RD_XFER) && !sd.sd_ack);
    assign tmo_hit   = (tmo_cnt == ACK_TIMEOUT - 16'd1);

    assign sd.sd_rd  = {1'b0, rd_req};
    assign sd.sd_wr  = {1'b0, wr_req};
    assign sd.sd_lba = lba_q;

    // SD side owns the single write port while busy, the CPU side otherwise.
    assign ram_we    = cpu_wr_ok || sd_wr_ok;
    assign ram_waddr = busy ? sd.sd_buff_addr : cpu_addr;
    assign ram_wdata = busy ? sd.sd_buff_dout : cpu_din;

    sector_ram u_ram (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .we       (ram_we),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .sd_addr  (sd.sd_buff_addr),
        .sd_dout  (sd.sd_buff_din),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rd_req     <= 1'b0;
            wr_req     <= 1'b0;
            lba_q      <= '0;
            valid      <= 1'b0;
            dirty      <= 1'b0;
            rd_pending <= 1'b0;
            cached_lba <= '0;
            target_lba <= '0;
            tmo_cnt    <= '0;
        end else begin
            done    <= 1'b0;
            tmo_cnt <= (in_xfer && !advance) ? tmo_cnt + 16'd1 : 16'd0;
            if (cpu_wr_ok)
                dirty <= 1'b1;

            if (in_xfer && !advance && tmo_hit) begin
                err        <= 1'b1;
                rd_req     <= 1'b0;
                wr_req     <= 1'b0;
                valid      <= 1'b0;
                dirty      <= 1'b0;
                rd_pending <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                state      <= DONE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        state <= IDLE;
                        if (req_rd) begin
                            err <= 1'b0;
                            if (hit) begin
                                done <= 1'b1;
                            end else begin
                                target_lba <= req_lba;
                                rd_pending <= 1'b1;
                                busy       <= 1'b1;
                                if (dirty) begin
                                    state  <= WB_REQ;
                                    wr_req <= 1'b1;
                                    lba_q  <= cached_lba;
                                end else begin
                                    state  <= RD_REQ;
                                    rd_req <= 1'b1;
                                    lba_q  <= req_lba;
                                end
                            end
                        end else if (req_flush) begin
                            err <= 1'b0;
                            if (dirty) begin
                                state      <= WB_REQ;
                                wr_req     <= 1'b1;
                                lba_q      <= cached_lba;
                                busy       <= 1'b1;
                                rd_pending <= 1'b0;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    WB_REQ: if (sd.sd_ack) begin
                        wr_req <= 1'b0;
                        state  <= WB_XFER;
                    end
                    WB_XFER: if (!sd.sd_ack) begin
                        dirty <= 1'b0;
                        if (rd_pending) begin
                            state  <= RD_REQ;
                            rd_req <= 1'b1;
                            lba_q  <= target_lba;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    RD_REQ: if (sd.sd_ack) begin
                        rd_req <= 1'b0;
                        valid  <= 1'b0;
                        state  <= RD_XFER;
                    end
                    RD_XFER: if (!sd.sd_ack) begin
                        cached_lba <= target_lba;
                        valid      <= 1'b1;
                        dirty      <= 1'b0;
                        rd_pending <= 1'b0;
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sector_cache_ctrl.sv
// Self-checking bench: directed vector table, randomized ops against a sector-level model, timeout and reset corners.
module tb_sector_cache_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] req_lba;
    logic        req_rd, req_flush;
    logic        busy, done, err;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic [7:0]  cpu_dout;

    logic [31:0] to_req_lba;
    logic        to_req_rd;
    logic        to_busy, to_done, to_err;
    logic [7:0]  to_cpu_dout;

    sector_cache_ctrl_if sd_bus ();
    sector_cache_ctrl_if to_bus ();

    always #5 clk_i = ~clk_i;

    sector_cache_ctrl dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_lba   (req_lba),
        .req_rd    (req_rd),
        .req_flush (req_flush),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_we    (cpu_we),
        .cpu_dout  (cpu_dout),
        .sd        (sd_bus)
    );

    sector_cache_ctrl #(.ACK_TIMEOUT(16'd16)) dut_to (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_lba   (to_req_lba),
        .req_rd    (to_req_rd),
        .req_flush (1'b0),
        .busy      (to_busy),
        .done      (to_done),
        .err       (to_err),
        .cpu_addr  (9'd0),
        .cpu_din   (8'd0),
        .cpu_we    (1'b0),
        .cpu_dout  (to_cpu_dout),
        .sd        (to_bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Event counters sampled on the falling edge, away from the active edge.
    int done_cnt = 0, busy_cnt = 0, rdreq_cnt = 0, wrreq_cnt = 0;
    always @(negedge clk_i) begin
        if (done === 1'b1)          done_cnt++;
        if (busy === 1'b1)          busy_cnt++;
        if (sd_bus.sd_rd[0] === 1'b1) rdreq_cnt++;
        if (sd_bus.sd_wr[0] === 1'b1) wrreq_cnt++;
    end

    // Reference model: resident sector contents/state plus a sparse disk image.
    logic [7:0]  m_buf [512];
    bit          m_valid, m_dirty;
    logic [31:0] m_lba;
    logic [7:0]  disk [longint unsigned];

    function automatic longint unsigned dkey(input logic [31:0] lba, input int i);
        return longint'(lba) * 512 + longint'(i);
    endfunction

    function automatic logic [7:0] disk_byte(input logic [31:0] lba, input int i);
        if (disk.exists(dkey(lba, i))) return disk[dkey(lba, i)];
        if (lba == 32'd5) return 8'(i) ^ 8'hA5;
        return 8'(i) ^ lba[7:0] ^ 8'h3C;
    endfunction

    task automatic serve_wr(input logic [31:0] exp_lba);
        int n = 0;
        int bad = 0;
        while (sd_bus.sd_wr[0] !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check("wb_req_seen", sd_bus.sd_wr[0], 1);
        if (sd_bus.sd_wr[0] !== 1'b1) return;
        check("wb_lba", sd_bus.sd_lba, exp_lba);
        sd_bus.sd_ack = 1'b1;
        tick();
        check("wb_req_dropped", sd_bus.sd_wr[0], 0);
        for (int i = 0; i < 512; i++) begin
            sd_bus.sd_buff_addr = 9'(i);
            #1;
            if (sd_bus.sd_buff_din !== m_buf[i]) begin
                if (bad == 0)
                    $display("FAIL wb_byte[%0d]: got %0h expected %0h", i, sd_bus.sd_buff_din, m_buf[i]);
                bad++;
            end
            tick();
        end
        check("wb_bad_bytes", bad, 0);
        sd_bus.sd_ack = 1'b0;
        tick();
    endtask

    task automatic serve_rd(input logic [31:0] lba);
        int n = 0;
        while (sd_bus.sd_rd[0] !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check("rd_req_seen", sd_bus.sd_rd[0], 1);
        if (sd_bus.sd_rd[0] !== 1'b1) return;
        check("rd_lba", sd_bus.sd_lba, lba);
        sd_bus.sd_ack = 1'b1;
        tick();
        check("rd_req_dropped", sd_bus.sd_rd[0], 0);
        for (int i = 0; i < 512; i++) begin
            sd_bus.sd_buff_addr = 9'(i);
            sd_bus.sd_buff_dout = disk_byte(lba, i);
            sd_bus.sd_buff_wr   = 1'b1;
            tick();
        end
        sd_bus.sd_buff_wr = 1'b0;
        sd_bus.sd_ack     = 1'b0;
        tick();
    endtask

    task automatic run_req(input bit rd, input bit fl, input logic [31:0] lba,
                           input bit exp_wb, input bit exp_rd);
        int d0 = done_cnt, b0 = busy_cnt, r0 = rdreq_cnt, w0 = wrreq_cnt;
        logic [31:0] wb_lba = m_lba;
        req_lba   = lba;
        req_rd    = rd;
        req_flush = fl;
        tick();
        req_rd    = 1'b0;
        req_flush = 1'b0;
        if (exp_wb) serve_wr(wb_lba);
        if (exp_rd) serve_rd(lba);
        check("done_at_end", done, 1);
        check("err_clear", err, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("done_pulses", done_cnt - d0, 1);
        if (!exp_wb) check("no_wr_traffic", wrreq_cnt - w0, 0);
        if (!exp_rd) check("no_rd_traffic", rdreq_cnt - r0, 0);
        if (!exp_wb && !exp_rd) check("busy_stays_low", busy_cnt - b0, 0);
        if (exp_wb) begin
            for (int i = 0; i < 512; i++) disk[dkey(wb_lba, i)] = m_buf[i];
            m_dirty = 1'b0;
        end
        if (exp_rd) begin
            for (int i = 0; i < 512; i++) m_buf[i] = disk_byte(lba, i);
            m_lba   = lba;
            m_valid = 1'b1;
            m_dirty = 1'b0;
        end
    endtask

    task automatic do_we(input logic [8:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_we   = 1'b1;
        tick();
        cpu_we = 1'b0;
        if (m_valid) begin
            m_buf[a] = d;
            m_dirty  = 1'b1;
        end
    endtask

    task automatic peek(input logic [8:0] a, input logic [7:0] exp);
        cpu_addr = a;
        tick();
        check("cpu_dout", cpu_dout, exp);
    endtask

    typedef enum logic [1:0] {OP_RD, OP_FLUSH, OP_WE, OP_PEEK} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] lba;
        logic [8:0]  addr;
        logic [7:0]  data;
        bit          exp_wb;
        bit          exp_rd;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] lbas [4];

    initial begin : main
        int n, d0;

        vecs[0]  = '{OP_RD,    32'd5, 9'h000, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{OP_PEEK,  32'd0, 9'h1FF, 8'h00, 1'b0, 1'b0, 8'h5A};
        vecs[2]  = '{OP_PEEK,  32'd0, 9'h000, 8'h00, 1'b0, 1'b0, 8'hA5};
        vecs[3]  = '{OP_RD,    32'd5, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{OP_WE,    32'd0, 9'h003, 8'h77, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{OP_PEEK,  32'd0, 9'h003, 8'h00, 1'b0, 1'b0, 8'h77};
        vecs[6]  = '{OP_RD,    32'd9, 9'h000, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[7]  = '{OP_FLUSH, 32'd0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{OP_PEEK,  32'd0, 9'h003, 8'h00, 1'b0, 1'b0, 8'h36};
        vecs[9]  = '{OP_WE,    32'd0, 9'h00A, 8'h12, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{OP_FLUSH, 32'd0, 9'h000, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{OP_FLUSH, 32'd0, 9'h000, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{OP_RD,    32'd5, 9'h000, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[13] = '{OP_PEEK,  32'd0, 9'h003, 8'h00, 1'b0, 1'b0, 8'h77};
        vecs[14] = '{OP_PEEK,  32'd0, 9'h00A, 8'h00, 1'b0, 1'b0, 8'hAF};
        vecs[15] = '{OP_RD,    32'd9, 9'h000, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[16] = '{OP_PEEK,  32'd0, 9'h00A, 8'h00, 1'b0, 1'b0, 8'h12};
        lbas[0] = 32'd5; lbas[1] = 32'd9; lbas[2] = 32'd12; lbas[3] = 32'd20;

        reset_i = 1'b1;
        req_lba = '0; req_rd = 1'b0; req_flush = 1'b0;
        cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0;
        sd_bus.sd_ack = 1'b0; sd_bus.sd_buff_addr = '0; sd_bus.sd_buff_dout = '0; sd_bus.sd_buff_wr = 1'b0;
        to_req_lba = '0; to_req_rd = 1'b0;
        to_bus.sd_ack = 1'b0; to_bus.sd_buff_addr = '0; to_bus.sd_buff_dout = '0; to_bus.sd_buff_wr = 1'b0;
        m_valid = 1'b0; m_dirty = 1'b0; m_lba = '0;
        for (int i = 0; i < 512; i++) m_buf[i] = 8'h00;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sd_rd", sd_bus.sd_rd, 0);
        check("rst_sd_wr", sd_bus.sd_wr, 0);
        check("rst_sd_lba", sd_bus.sd_lba, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        repeat (3) tick();
        reset_i = 1'b0;
        tick();

        // Ack timeout on the short-timeout instance.
        to_req_lba = 32'd7;
        to_req_rd  = 1'b1;
        tick();
        to_req_rd = 1'b0;
        check("to_busy", to_busy, 1);
        n = 0;
        while (to_bus.sd_rd[0] === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("to_rd_high_cycles", n, 16);
        check("to_done", to_done, 1);
        check("to_err_set", to_err, 1);
        check("to_busy_low", to_busy, 0);
        tick();
        check("to_done_pulse", to_done, 0);
        check("to_err_sticky", to_err, 1);
        to_req_rd = 1'b1;
        tick();
        to_req_rd = 1'b0;
        check("to_retry_miss", to_bus.sd_rd[0], 1);
        check("to_err_cleared", to_err, 0);

        // Directed vectors.
        for (int v = 0; v < 17; v++) begin
            case (vecs[v].op)
                OP_RD:    run_req(1'b1, 1'b0, vecs[v].lba, vecs[v].exp_wb, vecs[v].exp_rd);
                OP_FLUSH: run_req(1'b0, 1'b1, 32'd0, vecs[v].exp_wb, vecs[v].exp_rd);
                OP_WE:    do_we(vecs[v].addr, vecs[v].data);
                default:  peek(vecs[v].addr, vecs[v].exp_dout);
            endcase
        end

        // Simultaneous rd+flush behaves as a read: dirty miss writes back, then reads.
        do_we(9'h1F0, 8'hC3);
        req_lba   = 32'd12;
        req_rd    = 1'b1;
        req_flush = 1'b1;
        tick();
        req_rd    = 1'b0;
        req_flush = 1'b0;
        serve_wr(m_lba);
        serve_rd(32'd12);
        check("rdfl_done", done, 1);
        for (int i = 0; i < 512; i++) disk[dkey(m_lba, i)] = m_buf[i];
        for (int i = 0; i < 512; i++) m_buf[i] = disk_byte(32'd12, i);
        m_lba = 32'd12; m_dirty = 1'b0;
        tick();

        // Randomized operations checked against the model.
        for (int k = 0; k < 16; k++) begin
            logic [31:0] l;
            bit          h;
            logic [8:0]  a;
            a = 9'($urandom_range(511, 0));
            case ($urandom_range(3, 0))
                0: begin
                    l = lbas[$urandom_range(3, 0)];
                    h = m_valid && (l == m_lba);
                    run_req(1'b1, 1'b0, l, !h && m_dirty, !h);
                end
                1: run_req(1'b0, 1'b1, 32'd0, m_dirty, 1'b0);
                2: do_we(a, 8'($urandom_range(255, 0)));
                default: peek(a, m_buf[a]);
            endcase
        end

        // Reset in the middle of a read transfer.
        run_req(1'b0, 1'b1, 32'd0, m_dirty, 1'b0);
        req_lba = 32'd33;
        req_rd  = 1'b1;
        tick();
        req_rd = 1'b0;
        n = 0;
        while (sd_bus.sd_rd[0] !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check("mr_rd_req", sd_bus.sd_rd[0], 1);
        sd_bus.sd_ack = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            sd_bus.sd_buff_addr = 9'(i);
            sd_bus.sd_buff_dout = disk_byte(32'd33, i);
            sd_bus.sd_buff_wr   = 1'b1;
            tick();
        end
        sd_bus.sd_buff_addr = 9'd100;
        check("mr_busy_before", busy, 1);
        d0 = done_cnt;
        #2;
        reset_i = 1'b1;
        #1;
        check("mr_sd_rd", sd_bus.sd_rd, 0);
        check("mr_sd_wr", sd_bus.sd_wr, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        sd_bus.sd_buff_wr = 1'b0;
        sd_bus.sd_ack     = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        check("mr_no_done", done_cnt - d0, 0);
        m_valid = 1'b0; m_dirty = 1'b0; m_lba = '0;
        run_req(1'b1, 1'b0, 32'd33, 1'b0, 1'b1);
        peek(9'd100, disk_byte(32'd33, 100));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/sector_cache_ctrl.md
Name: sector_cache_ctrl

Overview:
- Upstream client of image_controller: the disk-controller side of the SD sector path.
- Holds one 512-byte sector in a local buffer and gives the Oric disk controller (FDC glue) byte-level read/write access to it.
- On a miss it requests the sector from image_controller over the sd_lba / sd_rd / sd_ack / sd_buff_* handshake. A dirty sector is written back first.
- Explicit flush requests perform the write-back on their own.

Parameters:
- LBA_W, 32, width of the client and SD LBA fields.
- ACK_TIMEOUT, 16'hFFFF, cycles to wait for sd_ack rise or fall before aborting with err.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous active-high reset
- req_lba  in  LBA_W  sector number requested by the client
- req_rd  in  1  one-cycle pulse: make sector req_lba resident
- req_flush  in  1  one-cycle pulse: write back the resident sector if dirty
- busy  out  1  transaction in progress; requests and cpu_we are ignored while high
- done  out  1  one-cycle pulse at the end of every accepted request
- err  out  1  sticky timeout flag, cleared by the next accepted request
- cpu_addr  in  9  byte offset within the sector
- cpu_din  in  8  write data
- cpu_we  in  1  byte write strobe; honoured only when busy=0 and valid=1
- cpu_dout  out  8  buffer[cpu_addr], registered, 1-cycle latency
- sd_lba  out  32  LBA presented to image_controller
- sd_rd  out  2  bit0 = read request; bit1 is tied 0
- sd_wr  out  2  bit0 = write request; bit1 is tied 0
- sd_ack  in  1  transfer-active indication from image_controller
- sd_buff_addr  in  9  byte index driven by image_controller
- sd_buff_dout  in  8  sector byte written into this block
- sd_buff_wr  in  1  write strobe for sd_buff_dout at sd_buff_addr
- sd_buff_din  out  8  buffer[sd_buff_addr], combinational (asynchronous read, valid in the same cycle)

Behaviour:
- Reset state (asynchronous): state IDLE; busy=0, done=0, err=0; sd_rd=0, sd_wr=0, sd_lba=0; valid=0, dirty=0, cached_lba=0, cpu_dout=0. Buffer contents are not reset. Reset asserted mid-transfer aborts immediately with no completion pulse.

State machine:
- IDLE
  - req_rd, hit (valid and req_lba==cached_lba): done next cycle, no SD traffic, busy stays 0.
  - req_rd, miss and dirty: latch target_lba, go to WB_REQ.
  - req_rd, miss and clean: latch target_lba, go to RD_REQ.
  - req_flush with dirty: go to WB_REQ.
  - req_flush while clean: done next cycle.
  - req_rd and req_flush in the same cycle: treated as req_rd; a dirty miss writes back anyway.
- WB_REQ: sd_lba=cached_lba, sd_wr[0]=1, busy=1. On sd_ack=1, drop sd_wr[0] and go to WB_XFER. sd_wr[0] must be low before image_controller returns to its poll state, otherwise it restarts the transfer.
- WB_XFER: buffer is read combinationally via sd_buff_din. On sd_ack falling: dirty=0, then go to RD_REQ if a read is pending, else DONE.
- RD_REQ: sd_lba=target_lba, sd_rd[0]=1. On sd_ack=1, drop sd_rd[0], set valid=0 and go to RD_XFER.
- RD_XFER: each sd_buff_wr writes sd_buff_dout into buffer[sd_buff_addr]. On sd_ack falling: cached_lba=target_lba, valid=1, dirty=0, go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.

Timeout:
- A counter runs in WB_REQ, WB_XFER, RD_REQ and RD_XFER and restarts on each state change.
- Reaching ACK_TIMEOUT: err=1, sd_rd=sd_wr=0, valid=0, dirty=0, go to DONE.

CPU port:
- cpu_we with valid=1 and busy=0 writes the buffer and sets dirty=1.
- The buffer has a single write port: the SD side owns it while busy, the CPU side owns it in IDLE, so there is no contention.
- cpu_dout always registers buffer[cpu_addr], including while busy.

Widths:
- sd_buff_addr and cpu_addr are 9 bits and address exactly 512 bytes; there is no wrap handling.
- target_lba and cached_lba are LBA_W wide and compare as full width.

Decomposition:
- Package sector_cache_pkg: state enum (IDLE, WB_REQ, WB_XFER, RD_REQ, RD_XFER, DONE) and constant SECTOR_BYTES=512.
- Sub-module sector_ram: 512x8 with one synchronous write port, one asynchronous read port (SD side) and one registered read port (CPU side).

Test Plan:
- Cold read: reset, then req_rd with lba=5. Expect sd_rd[0] high until ack and sd_lba=5. A model streams 512 bytes of i^8'hA5. Expect done, then cpu_addr=0x1FF reads 0x5A one cycle later.
- Hit: req_rd with lba=5 again. Expect done on the next cycle, sd_rd stays 0, busy stays 0.
- Dirty miss: cpu_we at addr 3 with 0x77, then req_rd with lba=9. Expect an sd_wr transfer with sd_lba=5 in which the model reads sd_buff_din=0x77 at addr 3, then an sd_rd transfer with sd_lba=9, then a single done.
- Flush clean: req_flush right after a read. Expect done in 1 cycle and no sd_wr.
- Timeout: req_rd with the model never acking, ACK_TIMEOUT=16. Expect sd_rd dropped after 16 cycles, err=1, done pulse, valid=0.
- Mid-transfer reset: assert reset_i at sd_buff_addr=100. Expect sd_rd, busy and done all 0 immediately; the next req_rd of the same lba misses.
